pipe_barrel_shifter: RTL

- Parametrised, fully pipelined barrel shifter for the f-add datapath.
- Used for mantissa alignment (right shift by exponent difference) and normalisation (left shift by leading-zero count).
- Structure: one mux layer per shift-amount bit (layer k shifts by 2^k), a register after every layer, and valid/ready flow control.
- Right shifts also produce a sticky bit (OR of all bits shifted out) for later rounding.

---
 rtl/bshift_pkg.sv | 21 ++
 rtl/bshift_stage.sv | 90 +++++++++
 rtl/pipe_barrel_shifter.sv | 70 +++++++
 3 files changed

// File: rtl/bshift_pkg.sv
// Shared mode encodings and elaboration helpers for pipe_barrel_shifter.
// BSHIFT_ROTATE_EN enables rotate-left on mode 2'b11.
package bshift_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SLL = 2'b00;
  localparam mode_t MODE_SRL = 2'b01;
  localparam mode_t MODE_SRA = 2'b10;
  localparam mode_t MODE_ROL = 2'b11;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bshift_stage.sv
// One shift layer (by STEP when shamt bit K is set) plus its pipeline register.
// BSHIFT_ROTATE_EN adds the rotate-left mux for mode 2'b11.
module bshift_stage
  import bshift_pkg::*;
#(
  parameter int WIDTH   = 11,
  parameter int SHAMT_W = 5,
  parameter int K       = 0,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               adv,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  mode_t              mode_i,
  input  logic               sticky_i,
  output logic               valid_o,
  output logic [WIDTH-1:0]   data_o,
  output logic [SHAMT_W-1:0] shamt_o,
  output mode_t              mode_o,
  output logic               sticky_o
);

  // A step of WIDTH or more empties the word; WIDTH-1 still gives full sign fill.
  localparam bit SAT = (STEP >= WIDTH);
  localparam int SH  = SAT ? WIDTH - 1 : STEP;

  logic               valid_q;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] shamt_q;
  mode_t              mode_q;
  logic               sticky_q, sticky_d;
  logic               dropped;

`ifdef BSHIFT_ROTATE_EN
  localparam int ROT = STEP % WIDTH;
  logic [2*WIDTH-1:0] rot_w;
  assign rot_w = {data_i, data_i} << ROT;
`endif

  always_comb begin
    dropped = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < STEP) dropped = dropped | data_i[i];
    end
    data_d   = data_i;
    sticky_d = sticky_i;
    if (shamt_i[K]) begin
      unique case (mode_i)
        MODE_SRL: begin
          data_d   = SAT ? '0 : data_i >> SH;
          sticky_d = sticky_i | dropped;
        end
        MODE_SRA: begin
          data_d   = $signed(data_i) >>> SH;
          sticky_d = sticky_i | dropped;
        end
`ifdef BSHIFT_ROTATE_EN
        MODE_ROL: data_d = rot_w[2*WIDTH-1:WIDTH];
`endif
        default: data_d = SAT ? '0 : data_i << SH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      shamt_q  <= '0;
      mode_q   <= MODE_SLL;
      sticky_q <= 1'b0;
    end else if (adv) begin
      valid_q  <= valid_i;
      data_q   <= data_d;
      shamt_q  <= shamt_i;
      mode_q   <= mode_i;
      sticky_q <= sticky_d;
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign shamt_o  = shamt_q;
  assign mode_o   = mode_q;
  assign sticky_o = sticky_q;

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Fully pipelined barrel shifter: one registered layer per shamt bit.
// Define BSHIFT_ROTATE_EN to make mode 2'b11 rotate left.
module pipe_barrel_shifter
  import bshift_pkg::*;
#(
  parameter int WIDTH   = 11,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky
);

  if (clog2(WIDTH) > SHAMT_W) begin : g_bad_shamt
    $error("SHAMT_W too narrow to cover WIDTH");
  end

  logic               adv;
  logic               v  [SHAMT_W+1];
  logic [WIDTH-1:0]   d  [SHAMT_W+1];
  logic [SHAMT_W-1:0] sh [SHAMT_W+1];
  mode_t              m  [SHAMT_W+1];
  logic               st [SHAMT_W+1];

  // Whole pipe moves in lockstep; a held output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign v[0]  = in_valid;
  assign d[0]  = in_data;
  assign sh[0] = in_shamt;
  assign m[0]  = in_mode;
  assign st[0] = 1'b0;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    bshift_stage #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W),
      .K       (k),
      .STEP    (1 << k)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .valid_i  (v[k]),
      .data_i   (d[k]),
      .shamt_i  (sh[k]),
      .mode_i   (m[k]),
      .sticky_i (st[k]),
      .valid_o  (v[k+1]),
      .data_o   (d[k+1]),
      .shamt_o  (sh[k+1]),
      .mode_o   (m[k+1]),
      .sticky_o (st[k+1])
    );
  end

  assign out_valid  = v[SHAMT_W];
  assign out_data   = d[SHAMT_W];
  assign out_sticky = st[SHAMT_W];

endmodule
